aggregation_argmax: RTL and testbench

- Downstream stage of the Transformation block in the GCN datapath.
- Captures every FM×WM product row (WEIGHT_COLS dot products per node) and walks the COO edge list one edge per cycle, accumulating neighbour rows per node.
- Then computes a per-node argmax over the aggregated columns, giving the final class address for each node (max_addi_answer).

---
 rtl/aggregation_argmax_if.sv | 35 +++
 rtl/aggregation_argmax.sv | 171 +++++++++++++++++
 tb/tb_aggregation_argmax.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aggregation_argmax_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aggregation_argmax_if : row-capture, COO-read and result bundle          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface aggregation_argmax_if #(
  parameter int FEATURE_ROWS      = 6,
  parameter int WEIGHT_COLS       = 3,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int NUM_OF_NODES      = 6,
  parameter int COO_NUM_OF_COLS   = 6,
  parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
  parameter int ROW_IDX_WIDTH     = $clog2(FEATURE_ROWS),
  parameter int MAX_ADDRESS_WIDTH = 2
);
  logic                         start;
  logic                         row_valid;
  logic [ROW_IDX_WIDTH-1:0]     row_index;
  logic [DOT_PROD_WIDTH-1:0]    fm_wm_row [WEIGHT_COLS];
  logic [COO_BW-1:0]            coo_address;
  logic [2*COO_BW-1:0]          coo_in;
  logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [NUM_OF_NODES];
  logic                         done;

  modport master (
    output start, row_valid, row_index, fm_wm_row, coo_in,
    input  coo_address, max_addi_answer, done
  );

  modport slave (
    input  start, row_valid, row_index, fm_wm_row, coo_in,
    output coo_address, max_addi_answer, done
  );
endinterface
`default_nettype wire

// File: rtl/aggregation_argmax.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aggregation_argmax : COO neighbour aggregation + per-node argmax (GCN)   |
// | Optional macro SELF_LOOP_EN seeds each accumulator with its own row.     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module aggregation_argmax #(
  parameter int FEATURE_ROWS      = 6,
  parameter int WEIGHT_COLS       = 3,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int NUM_OF_NODES      = 6,
  parameter int COO_NUM_OF_COLS   = 6,
  parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
  parameter int ROW_IDX_WIDTH     = $clog2(FEATURE_ROWS),
  parameter int MAX_ADDRESS_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  aggregation_argmax_if.slave  bus
);
  localparam int NODE_W = (NUM_OF_NODES > 1) ? $clog2(NUM_OF_NODES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_AGG    = 3'd2,
    S_ARGMAX = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                       state_q, state_d;
  logic [DOT_PROD_WIDTH-1:0]    buffer_q [FEATURE_ROWS][WEIGHT_COLS];
  logic [DOT_PROD_WIDTH-1:0]    buffer_d [FEATURE_ROWS][WEIGHT_COLS];
  logic [DOT_PROD_WIDTH-1:0]    acc_q    [NUM_OF_NODES][WEIGHT_COLS];
  logic [DOT_PROD_WIDTH-1:0]    acc_d    [NUM_OF_NODES][WEIGHT_COLS];
  logic [FEATURE_ROWS-1:0]      mask_q, mask_d;
  logic [COO_BW-1:0]            coo_address_q, coo_address_d;
  logic [NODE_W-1:0]            node_q, node_d;
  logic [MAX_ADDRESS_WIDTH-1:0] answer_q [NUM_OF_NODES];
  logic [MAX_ADDRESS_WIDTH-1:0] answer_d [NUM_OF_NODES];
  logic                         done_q, done_d;

  logic [COO_BW-1:0]            src, dst;
  logic                         edge_ok;
  logic [DOT_PROD_WIDTH-1:0]    best;
  logic [MAX_ADDRESS_WIDTH-1:0] best_idx;

  assign src     = bus.coo_in[2*COO_BW-1 -: COO_BW];
  assign dst     = bus.coo_in[COO_BW-1:0];
  assign edge_ok = (int'(src) < NUM_OF_NODES) && (int'(dst) < NUM_OF_NODES);

  // Strict greater-than keeps the lowest column on ties.
  always_comb begin
    best     = acc_q[node_q][0];
    best_idx = '0;
    for (int c = 1; c < WEIGHT_COLS; c++) begin
      if (acc_q[node_q][c] > best) begin
        best     = acc_q[node_q][c];
        best_idx = MAX_ADDRESS_WIDTH'(c);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    buffer_d      = buffer_q;
    acc_d         = acc_q;
    mask_d        = mask_q;
    coo_address_d = coo_address_q;
    node_d        = node_q;
    answer_d      = answer_q;
    done_d        = done_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mask_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.row_valid && (int'(bus.row_index) < FEATURE_ROWS)) begin
          buffer_d[bus.row_index] = bus.fm_wm_row;
          mask_d[bus.row_index]   = 1'b1;
        end
        // buffer_d so the row captured on this very cycle seeds its own node.
        if (&mask_d) begin
          state_d       = S_AGG;
          coo_address_d = '0;
          for (int n = 0; n < NUM_OF_NODES; n++) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
`ifdef SELF_LOOP_EN
              acc_d[n][c] = buffer_d[n][c];
`else
              acc_d[n][c] = '0;
`endif
            end
          end
        end
      end
      S_AGG: begin
        if (edge_ok) begin
          for (int c = 0; c < WEIGHT_COLS; c++) begin
            acc_d[src][c] = acc_d[src][c] + buffer_q[dst][c];
            if (src != dst) begin
              acc_d[dst][c] = acc_d[dst][c] + buffer_q[src][c];
            end
          end
        end
        if (int'(coo_address_q) == COO_NUM_OF_COLS - 1) begin
          state_d       = S_ARGMAX;
          coo_address_d = '0;
          node_d        = '0;
        end else begin
          coo_address_d = coo_address_q + COO_BW'(1);
        end
      end
      S_ARGMAX: begin
        answer_d[node_q] = best_idx;
        if (int'(node_q) == NUM_OF_NODES - 1) begin
          state_d = S_DONE;
        end else begin
          node_d = node_q + NODE_W'(1);
        end
      end
      S_DONE: begin
        // done asserts one cycle after entering DONE; start is only honoured once it is visible.
        done_d = 1'b1;
        if (!bus.start && done_q) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      coo_address_q <= '0;
      node_q        <= '0;
      done_q        <= 1'b0;
      for (int n = 0; n < FEATURE_ROWS; n++) begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          buffer_q[n][c] <= '0;
        end
      end
      for (int n = 0; n < NUM_OF_NODES; n++) begin
        answer_q[n] <= '0;
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          acc_q[n][c] <= '0;
        end
      end
    end else begin
      state_q       <= state_d;
      buffer_q      <= buffer_d;
      acc_q         <= acc_d;
      mask_q        <= mask_d;
      coo_address_q <= coo_address_d;
      node_q        <= node_d;
      answer_q      <= answer_d;
      done_q        <= done_d;
    end
  end

  assign bus.coo_address     = coo_address_q;
  assign bus.max_addi_answer = answer_q;
  assign bus.done            = done_q;
endmodule
`default_nettype wire

// File: tb/tb_aggregation_argmax.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_aggregation_argmax : directed + random passes against a ref model     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_aggregation_argmax;
  localparam int N   = 6;
  localparam int C   = 3;
  localparam int E   = 6;
  localparam int LAT = E + N + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aggregation_argmax_if bus ();
  aggregation_argmax dut (.clk(clk), .reset(reset), .bus(bus.slave));

  logic [5:0]  edge_tab [8];
  logic [15:0] rows_m   [N][C];
  logic [1:0]  exp_ans  [N];
  int vectors     = 0;
  int miscompares = 0;

  always_comb bus.coo_in = edge_tab[bus.coo_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: sum neighbour rows over the edge list, then pick the first column holding the maximum.
  function automatic void model();
    int acc [N][C];
    int s, d, mx;
    for (int n = 0; n < N; n++)
      for (int c = 0; c < C; c++) begin
`ifdef SELF_LOOP_EN
        acc[n][c] = int'(rows_m[n][c]);
`else
        acc[n][c] = 0;
`endif
      end
    for (int e = 0; e < E; e++) begin
      s = int'(edge_tab[e] >> 3);
      d = int'(edge_tab[e] & 6'o07);
      if (s < N && d < N) begin
        for (int c = 0; c < C; c++) begin
          acc[s][c] = (acc[s][c] + int'(rows_m[d][c])) % 65536;
          if (s != d) acc[d][c] = (acc[d][c] + int'(rows_m[s][c])) % 65536;
        end
      end
    end
    for (int n = 0; n < N; n++) begin
      mx = 0;
      for (int c = 0; c < C; c++) if (acc[n][c] > mx) mx = acc[n][c];
      exp_ans[n] = 2'd0;
      for (int c = C - 1; c >= 0; c--) if (acc[n][c] == mx) exp_ans[n] = 2'(c);
    end
  endfunction

  task automatic clear_edges();
    for (int i = 0; i < 8; i++) edge_tab[i] = 6'o77;
  endtask

  task automatic send_row(input int idx, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    @(negedge clk);
    bus.row_valid    = 1'b1;
    bus.row_index    = 3'(idx);
    bus.fm_wm_row[0] = a;
    bus.fm_wm_row[1] = b;
    bus.fm_wm_row[2] = c;
    if (idx < N) begin
      rows_m[idx][0] = a;
      rows_m[idx][1] = b;
      rows_m[idx][2] = c;
    end
  endtask

  task automatic begin_pass();
    @(negedge clk);
    bus.start     = 1'b1;
    bus.row_valid = 1'b0;
  endtask

  // Called right after the row that completes the set has been driven.
  task automatic finish_pass(input string tag);
    int cnt;
    cnt = 0;
    model();
    do begin
      @(negedge clk);
      bus.row_valid = 1'b0;
      cnt++;
    end while (!bus.done && cnt < 40);
    chk({tag, "_latency"}, 32'(cnt - 1), 32'(LAT));
    for (int n = 0; n < N; n++)
      chk($sformatf("%s_ans%0d", tag, n), 32'(bus.max_addi_answer[n]), 32'(exp_ans[n]));
    repeat (2) @(negedge clk);
    chk({tag, "_hold"}, 32'(bus.done), 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, "_drop"}, 32'(bus.done), 32'd0);
    chk({tag, "_coo_idle"}, 32'(bus.coo_address), 32'd0);
  endtask

  task automatic send_t1_rows();
    send_row(0, 16'd1, 16'd2, 16'd9);
    send_row(1, 16'd5, 16'd3, 16'd4);
    for (int i = 2; i < N; i++) send_row(i, 16'd0, 16'd0, 16'd0);
  endtask

  task automatic rand_pass(input int p);
    logic [N-1:0] seen;
    int idx, tries;
    logic [15:0] v [C];
    seen = '0;
    tries = 0;
    for (int e = 0; e < E; e++) edge_tab[e] = 6'($urandom_range(0, 63));
    begin_pass();
    while (!(&seen)) begin
      idx = (tries < 20) ? int'($urandom_range(0, 7)) : 0;
      if (tries >= 20) while (seen[idx]) idx++;
      for (int c = 0; c < C; c++)
        v[c] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      send_row(idx, v[0], v[1], v[2]);
      if (idx < N) seen[idx] = 1'b1;
      if (!(&seen) && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.row_valid = 1'b0;
      end
      tries++;
    end
    finish_pass($sformatf("rand%0d", p));
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.row_valid = 1'b0;
    bus.row_index = '0;
    for (int c = 0; c < C; c++) bus.fm_wm_row[c] = '0;
    clear_edges();
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_coo", 32'(bus.coo_address), 32'd0);
    for (int n = 0; n < N; n++) chk($sformatf("rst_ans%0d", n), 32'(bus.max_addi_answer[n]), 32'd0);
    reset = 1'b0;

    // Basic aggregation
    clear_edges();
    edge_tab[0] = 6'o01;
    begin_pass();
    send_t1_rows();
    finish_pass("t1");
    chk("t1_ans1_const", 32'(bus.max_addi_answer[1]), 32'd2);

    // Tie resolves to column 0
    begin_pass();
    send_row(0, 16'd0, 16'd0, 16'd0);
    send_row(1, 16'd7, 16'd7, 16'd7);
    for (int i = 2; i < N; i++) send_row(i, 16'd0, 16'd0, 16'd0);
    finish_pass("tie");
    chk("tie_const", 32'(bus.max_addi_answer[0]), 32'd0);

    // Modulo 2^16 accumulation
    clear_edges();
    edge_tab[0] = 6'o01;
    edge_tab[1] = 6'o02;
    begin_pass();
    send_row(0, 16'd0, 16'd0, 16'd0);
    send_row(1, 16'h8000, 16'h0001, 16'd0);
    send_row(2, 16'h8000, 16'h0001, 16'd0);
    for (int i = 3; i < N; i++) send_row(i, 16'd0, 16'd0, 16'd0);
    finish_pass("wrap");
    chk("wrap_const", 32'(bus.max_addi_answer[0]), 32'd1);

    // Out-of-order with duplicate; LOAD must wait for index 4
    clear_edges();
    edge_tab[0] = 6'o34;
    begin_pass();
    send_row(5, 16'd0, 16'd0, 16'd0);
    send_row(3, 16'd9, 16'd0, 16'd0);
    send_row(3, 16'd0, 16'd0, 16'd9);
    send_row(0, 16'd0, 16'd0, 16'd0);
    send_row(1, 16'd0, 16'd0, 16'd0);
    send_row(2, 16'd0, 16'd0, 16'd0);
    repeat (4) begin
      @(negedge clk);
      bus.row_valid = 1'b0;
    end
    chk("ooo_still_load", 32'(bus.coo_address), 32'd0);
    chk("ooo_no_done", 32'(bus.done), 32'd0);
    send_row(4, 16'd0, 16'd0, 16'd0);
    finish_pass("ooo");
    chk("ooo_const", 32'(bus.max_addi_answer[4]), 32'd2);

    // Reset during AGG, then rerun the basic pass
    clear_edges();
    edge_tab[0] = 6'o01;
    begin_pass();
    send_t1_rows();
    repeat (3) begin
      @(negedge clk);
      bus.row_valid = 1'b0;
    end
    chk("agg_coo", 32'(bus.coo_address), 32'd2);
    reset     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("agg_rst_done", 32'(bus.done), 32'd0);
    chk("agg_rst_coo", 32'(bus.coo_address), 32'd0);
    for (int n = 0; n < N; n++) chk($sformatf("agg_rst_ans%0d", n), 32'(bus.max_addi_answer[n]), 32'd0);
    reset = 1'b0;
    begin_pass();
    send_t1_rows();
    finish_pass("t1b");

    // Self loop only
    clear_edges();
    begin_pass();
    for (int i = 0; i < N; i++)
      send_row(i, 16'd0, (i == 2) ? 16'd6 : 16'd0, 16'd0);
    finish_pass("self");
`ifdef SELF_LOOP_EN
    chk("self_const", 32'(bus.max_addi_answer[2]), 32'd1);
`else
    chk("self_const", 32'(bus.max_addi_answer[2]), 32'd0);
`endif

    for (int p = 0; p < 10; p++) rand_pass(p);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
